sync_up_counter_gl: RTL and testbench
=====================================

// Module: sync_up_counter_gl
// PURPOSE
//  Gate-level synchronous up counter; counting complement of the 4-bit down counter.
//  Counts 0 -> MAX_COUNT and wraps, with enable, parallel load and terminal-count/carry
//  outputs for cascading digits (e.g. BCD with MAX_COUNT=9) in the lab timer datapath.
//  Next-state logic built from gate primitives (and/xor/or/not); one flop per bit.
// PARAMETERS
//  WIDTH      4              counter width in bits (>=2)
//  MAX_COUNT  (1<<WIDTH)-1   terminal value; count wraps MAX_COUNT -> 0
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst       in   1      synchronous reset, active-high
//  en        in   1      count enable
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  value loaded when load=1
//  out       out  WIDTH  current count (registered)
//  tc        out  1      terminal count: out >= MAX_COUNT (combinational from out)
//  co        out  1      carry out: tc & en & ~load (enable for next cascaded stage)
// BEHAVIOUR
//  - Reset: rst=1 at posedge -> out=0 next cycle; tc=0, co=0 (unless MAX_COUNT=0, unused).
//  - Priority per posedge: rst > load > en > hold.
//    rst=1                  -> out <= 0
//    load=1                 -> out <= load_val (en ignored)
//    en=1, out <  MAX_COUNT -> out <= out+1
//    en=1, out >= MAX_COUNT -> out <= 0 (wrap; see SATURATE below)
//    en=0                   -> out holds
//  - Latency: one clock from qualifying edge to new out; tc/co follow out combinationally.
//  - Increment: bit i toggles when en & (AND of bits 0..i-1); wrap implemented by
//    synchronous clear gated by tc, not by modular arithmetic beyond WIDTH.
//  - Out-of-range load (load_val > MAX_COUNT): value loaded as-is; tc=1; next enabled
//    edge wraps to 0.
//  - Full-range case (MAX_COUNT=2^WIDTH-1): wrap equals natural overflow; tc=1 at all-ones.
//  - rst asserted mid-count or together with load/en: rst wins; load_val discarded.
//  - No internal state besides out; no X propagation after first reset edge.
// CONFIGURATION
//  UP_COUNTER_SATURATE_EN
//   defined:   en=1 with out >= MAX_COUNT -> out <= MAX_COUNT (saturate; out-of-range
//              values clamp to MAX_COUNT); co still asserts while tc & en & ~load.
//   undefined: wrap to 0 as above (default build).
// TESTING
//  1 rst=1 one edge, en=0 -> out=0, tc=0, co=0; out holds 0 for 3 edges with en=0.
//  2 WIDTH=4 default, en=1 for 17 edges -> out 1..15,0,1; tc=1/co=1 only while out=15.
//  3 en=1, at out=5 drop en 2 cycles -> out stays 5; re-raise -> 6,7.
//  4 out=7, load=1 load_val=12 en=1 same edge -> out=12 (no increment), co=0 that cycle.
//  5 out=9, rst=1 with load=1 load_val=3 -> out=0 next cycle.
//  6 MAX_COUNT=9: count 8,9,0 with tc=1 at 9; load 13 -> tc=1, next en edge -> 0;
//    with UP_COUNTER_SATURATE_EN: 9 holds at 9, load 13 -> next en edge -> 9.

Source files
------------

// File: rtl/sync_up_counter_gl_if.sv
// sync_up_counter_gl_if: control/status bundle for sync_up_counter_gl.
//   en        count enable
//   load      parallel load strobe
//   load_val  value loaded when load=1
//   out       current count (registered)
//   tc        terminal count, out >= MAX_COUNT
//   co        carry out, tc & en & ~load
// master: the block driving the counter; slave: the counter itself.
interface sync_up_counter_gl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] out;
    logic             tc;
    logic             co;

    modport master (
        output en, load, load_val,
        input  out, tc, co
    );

    modport slave (
        input  en, load, load_val,
        output out, tc, co
    );
endinterface

// File: rtl/sync_up_counter_gl.sv
// sync_up_counter_gl: gate-level synchronous up counter, 0 -> MAX_COUNT then wrap.
// Cascadable through co (e.g. BCD digits with MAX_COUNT=9).
// Ports:
//   clk   clock, rising edge
//   rst   synchronous reset, active-high
//   bus   sync_up_counter_gl_if.slave (en, load, load_val in; out, tc, co out)
// Priority per edge: rst > load > en > hold.
// Optional feature: define UP_COUNTER_SATURATE_EN to clamp at MAX_COUNT instead of
// wrapping to 0 (co still asserts on tc & en & ~load).
module sync_up_counter_gl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
    input logic                 clk,
    input logic                 rst,
    sync_up_counter_gl_if.slave bus
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] inc;
    logic [WIDTH-1:0] cnt_nxt;
    logic             en;
    logic             load;
    logic             tc;
    logic             co;
    logic             wrap;
    logic             n_wrap;
    logic             n_load;

    assign en   = bus.en;
    assign load = bus.load;

    // Out-of-range values (loaded above MAX_COUNT) also count as terminal.
    assign tc = (out_q >= MaxVal);

    and g_wrap  (wrap, en, tc);
    not g_nwrap (n_wrap, wrap);
    not g_nload (n_load, load);
    and g_co    (co, tc, en, n_load);

    // Ripple toggle chain: bit i toggles when en and all lower bits are 1.
    assign carry[0] = en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        xor g_inc (inc[i], out_q[i], carry[i]);

        if (i < WIDTH - 1) begin : g_carry
            and g_c (carry[i+1], carry[i], out_q[i]);
        end

`ifdef UP_COUNTER_SATURATE_EN
        logic keep;
        logic clamp;
        // At terminal count force MAX_COUNT instead of the incremented value.
        and g_keep  (keep, inc[i], n_wrap);
        and g_clamp (clamp, wrap, MaxVal[i]);
        or  g_sel   (cnt_nxt[i], keep, clamp);
`else
        // Synchronous clear gated by tc; no reliance on natural overflow.
        and g_clr (cnt_nxt[i], inc[i], n_wrap);
`endif
    end

    always_comb begin
        out_d = cnt_nxt;
        if (load) begin
            out_d = bus.load_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;
    assign bus.tc  = tc;
    assign bus.co  = co;

endmodule

// File: tb/tb_sync_up_counter_gl.sv
// Directed bench for sync_up_counter_gl: a full-range instance (MAX 15) and a
// decade instance (MAX 9), each checked against a scoreboard of expected counts.
module tb_sync_up_counter_gl;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    sync_up_counter_gl_if #(.WIDTH(W)) bus_a ();
    sync_up_counter_gl_if #(.WIDTH(W)) bus_b ();

    sync_up_counter_gl #(.WIDTH(W), .MAX_COUNT(15)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    sync_up_counter_gl #(.WIDTH(W), .MAX_COUNT(9)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q_a[$];
    logic [W-1:0] q_b[$];
    logic [W-1:0] model_a;
    logic [W-1:0] model_b;
    bit           init_a = 1'b0;
    bit           init_b = 1'b0;

    function automatic logic [W-1:0] next_val(input logic [W-1:0] cur, input logic r,
                                              input logic l, input logic [W-1:0] lv,
                                              input logic e, input int unsigned mx);
        if (r) return '0;
        if (l) return lv;
        if (e) begin
            if (int'(cur) >= int'(mx)) begin
`ifdef UP_COUNTER_SATURATE_EN
                return W'(mx);
`else
                return '0;
`endif
            end
            return cur + 1'b1;
        end
        return cur;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step_a(input logic r, input logic l, input logic [W-1:0] lv,
                          input logic e);
        logic [W-1:0] exp;
        rst_a = r;
        bus_a.load = l;
        bus_a.load_val = lv;
        bus_a.en = e;
        #1;
        if (init_a) chk("co_a", 32'(bus_a.co), 32'((model_a >= 4'd15) & e & ~l));
        q_a.push_back(next_val(model_a, r, l, lv, e, 15));
        @(posedge clk);
        #1;
        exp = q_a.pop_front();
        model_a = exp;
        init_a = 1'b1;
        chk("out_a", 32'(bus_a.out), 32'(exp));
        chk("tc_a", 32'(bus_a.tc), 32'(exp >= 4'd15));
    endtask

    task automatic step_b(input logic r, input logic l, input logic [W-1:0] lv,
                          input logic e);
        logic [W-1:0] exp;
        rst_b = r;
        bus_b.load = l;
        bus_b.load_val = lv;
        bus_b.en = e;
        #1;
        if (init_b) chk("co_b", 32'(bus_b.co), 32'((model_b >= 4'd9) & e & ~l));
        q_b.push_back(next_val(model_b, r, l, lv, e, 9));
        @(posedge clk);
        #1;
        exp = q_b.pop_front();
        model_b = exp;
        init_b = 1'b1;
        chk("out_b", 32'(bus_b.out), 32'(exp));
        chk("tc_b", 32'(bus_b.tc), 32'(exp >= 4'd9));
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.en = 1'b0;
        bus_a.load = 1'b0;
        bus_a.load_val = '0;
        bus_b.en = 1'b0;
        bus_b.load = 1'b0;
        bus_b.load_val = '0;

        // Reset, then hold at 0 with en low.
        step_a(1'b1, 1'b0, 4'd0, 1'b0);
        chk("co_rst_a", 32'(bus_a.co), 32'd0);
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 4'd0, 1'b0);

        // Full-range run: 1..15, 0, 1.
        for (int i = 0; i < 17; i++) step_a(1'b0, 1'b0, 4'd0, 1'b1);

        // Count to 5, hold 2 cycles, resume to 7.
        for (int i = 0; i < 4; i++) step_a(1'b0, 1'b0, 4'd0, 1'b1);
        step_a(1'b0, 1'b0, 4'd0, 1'b0);
        step_a(1'b0, 1'b0, 4'd0, 1'b0);
        step_a(1'b0, 1'b0, 4'd0, 1'b1);
        step_a(1'b0, 1'b0, 4'd0, 1'b1);

        // Load with en on the same edge: load wins.
        step_a(1'b0, 1'b1, 4'd12, 1'b1);
        // Load at all-ones with en: co must stay low.
        step_a(1'b0, 1'b1, 4'd15, 1'b0);
        step_a(1'b0, 1'b1, 4'd9, 1'b1);
        // Reset beats load.
        step_a(1'b1, 1'b1, 4'd3, 1'b1);
        step_a(1'b0, 1'b0, 4'd0, 1'b1);

        // Decade counter.
        step_b(1'b1, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 11; i++) step_b(1'b0, 1'b0, 4'd0, 1'b1);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);
        // Out-of-range load, then enabled edges.
        step_b(1'b0, 1'b1, 4'd13, 1'b0);
        step_b(1'b0, 1'b0, 4'd0, 1'b0);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);
        step_b(1'b0, 1'b1, 4'd8, 1'b0);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);
        step_b(1'b0, 1'b0, 4'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the clock or a step stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
